// File: rtl/syscall_unit_if.sv
// Request/print bus between the processor, syscall_unit and the print consumer.
// master = processor/consumer side, slave = syscall_unit side.
interface syscall_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           instr_ID;
  logic [DATA_WIDTH-1:0] rs;
  logic [DATA_WIDTH-1:0] rt;
  logic [DATA_WIDTH-1:0] rd;
  logic                  rd_valid;
  logic                  print_valid;
  logic [DATA_WIDTH-1:0] print_data;
  logic                  print_ready;
  logic [CNT_W-1:0]      fifo_count;
  logic                  halt;

  modport master (
    output issue_valid, instr_ID, rs, rt, print_ready,
    input  issue_ready, rd, rd_valid, print_valid, print_data, fifo_count, halt
  );

  modport slave (
    input  issue_valid, instr_ID, rs, rt, print_ready,
    output issue_ready, rd, rd_valid, print_valid, print_data, fifo_count, halt
  );
endinterface

// File: rtl/syscall_unit.sv
// syscall_unit: clocked system-call controller with a FWFT display FIFO and a
// drain-then-delay exit sequence ending in a sticky halt.
// Optional macro SYSCALL_UNIT_TRACE_EN adds simulation-only print/$finish tracing.
// DATA_WIDTH/FIFO_DEPTH must match the parameters of the connected interface.
module syscall_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned EXIT_DELAY = 5,
  parameter int unsigned SYSCALL_ID = 26
) (
  input  logic           clk,
  input  logic           reset,
  syscall_unit_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DLY_W = (EXIT_DELAY > 1) ? $clog2(EXIT_DELAY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COUNT, S_HALTED} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [DLY_W-1:0]      r_delay;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_rd_valid;
  logic                  r_halt;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_issue_ready;
  logic w_accept;
  logic w_is_sys;
  logic w_push;
  logic w_exit;
  logic w_status;

  // Handshake and decode; a full FIFO still accepts when the head pops this cycle.
  assign w_empty       = (r_count == CNT_W'(0));
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop         = !w_empty && bus.print_ready;
  assign w_issue_ready = (r_state == S_IDLE) && !(w_full && !w_pop);
  assign w_accept      = bus.issue_valid && w_issue_ready;
  assign w_is_sys      = w_accept && (bus.instr_ID == 32'(SYSCALL_ID));
  assign w_push        = w_is_sys && (bus.rs == DATA_WIDTH'(1));
  assign w_exit        = w_is_sys && (bus.rs == DATA_WIDTH'(2));
  assign w_status      = w_is_sys && (bus.rs == DATA_WIDTH'(3));

  assign bus.issue_ready = w_issue_ready;
  assign bus.print_valid = !w_empty;
  assign bus.print_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.fifo_count  = r_count;
  assign bus.rd          = r_rd;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.halt        = r_halt;

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.rt;
  end

  // FIFO pointers, status result and the exit FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_delay    <= '0;
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_rd_valid <= w_status;
      if (w_status) r_rd <= DATA_WIDTH'(r_count);

      case (r_state)
        S_IDLE: begin
          if (w_exit) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // First empty cycle here starts the EXIT_DELAY-cycle countdown.
          if (w_empty) begin
            if (EXIT_DELAY <= 1) begin
              r_state <= S_HALTED;
              r_halt  <= 1'b1;
            end else begin
              r_delay <= DLY_W'(EXIT_DELAY - 1);
              r_state <= S_COUNT;
            end
          end
        end
        S_COUNT: begin
          // Leaving on the last count keeps the latency at exactly EXIT_DELAY.
          if (r_delay <= DLY_W'(1)) begin
            r_state <= S_HALTED;
            r_halt  <= 1'b1;
          end else begin
            r_delay <= r_delay - DLY_W'(1);
          end
        end
        default: begin
          r_halt <= 1'b1;
        end
      endcase
    end
  end

`ifdef SYSCALL_UNIT_TRACE_EN
  logic r_fin;

  // Simulation-only trace: print each popped value and end the run after halting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fin <= 1'b0;
    end else begin
      if (w_pop) $display("%0d", bus.print_data);
      if (r_state == S_HALTED) r_fin <= 1'b1;
      if (r_fin) $finish;
    end
  end
`endif
endmodule
